// File: rtl/fx2_pkg.sv
// fx2_pkg: shared constants and FSM state encoding for the FX2 slave-FIFO master
package fx2_pkg;
  localparam int FX2_PKT_SIZE = 512;
  localparam int PKT_CNT_W = $clog2(FX2_PKT_SIZE);
  localparam logic [1:0] DEF_OUT_ADR = 2'b10;
  localparam logic [1:0] DEF_IN_ADR = 2'b00;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADR_OUT = 3'd1;
  localparam logic [2:0] ST_RD = 3'd2;
  localparam logic [2:0] ST_ADR_IN = 3'd3;
  localparam logic [2:0] ST_WR = 3'd4;
  localparam logic [2:0] ST_PKTEND = 3'd5;
  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    ADR_OUT = ST_ADR_OUT,
    RD = ST_RD,
    ADR_IN = ST_ADR_IN,
    WR = ST_WR,
    PKTEND = ST_PKTEND
  } fx2_state_e;
endpackage

// File: rtl/fx2_pktend_timer.sv
// fx2_pktend_timer: tracks bytes in the open IN packet and idle time, raising pend_end when a short packet should be committed
module fx2_pktend_timer
  import fx2_pkg::*;
#(
  parameter int PKTEND_TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wr_i,
  input  logic clr_i,
  input  logic flush_i,
  output logic pend_end_o
);
  localparam logic [15:0] TMO = 16'(PKTEND_TIMEOUT);
  logic [PKT_CNT_W-1:0] pkt_q, pkt_d;
  logic [15:0] idle_q, idle_d;
  // pkt count wraps at the FX2 packet size (auto-commit); idle time saturates at the timeout
  always_comb begin
    pkt_d = clr_i ? '0 : wr_i ? pkt_q + PKT_CNT_W'(1) : pkt_q;
    idle_d = (wr_i || clr_i || pkt_q == '0) ? '0 : (idle_q < TMO) ? idle_q + 16'd1 : idle_q;
    pend_end_o = (pkt_q != '0) && (idle_q >= TMO || flush_i);
  end
  // counter registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      pkt_q <= '0;
      idle_q <= '0;
    end else begin
      pkt_q <= pkt_d;
      idle_q <= idle_d;
    end
endmodule

// File: rtl/fx2_fifo_master.sv
// fx2_fifo_master: FPGA-side FX2 slave-FIFO master; optional byte/packet counters under FX2_FIFO_MASTER_STATS_EN
module fx2_fifo_master
  import fx2_pkg::*;
#(
  parameter logic [1:0] OUT_ADR = DEF_OUT_ADR,
  parameter logic [1:0] IN_ADR = DEF_IN_ADR,
  parameter int MAX_BURST = 64,
  parameter int PKTEND_TIMEOUT = 1024
) (
  input  logic        ifclk,
  input  logic        reset_n,
  output logic [1:0]  fifoadr,
  output logic        slrd,
  output logic        slwr,
  output logic        pktend,
  input  logic [7:0]  fd_in,
  output logic [7:0]  fd_out,
  output logic        fd_oe,
  input  logic        empty,
  input  logic        full,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic        tx_flush
`ifdef FX2_FIFO_MASTER_STATS_EN
  ,
  output logic [31:0] rx_count,
  output logic [31:0] tx_count,
  output logic [15:0] pktend_count
`endif
);
  localparam logic [7:0] MB = 8'(MAX_BURST);
  fx2_state_e state_q, state_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] burst_q, burst_d;
  logic prefer_wr_q, prefer_wr_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d;
  logic want_rd, want_wr, pend_end, rd_cap, wr_cap, stall, rd_go, wr_go;
  fx2_pktend_timer #(.PKTEND_TIMEOUT(PKTEND_TIMEOUT)) u_timer (
    .clk_i(ifclk),
    .rst_ni(reset_n),
    .wr_i(wr_go),
    .clr_i(pktend),
    .flush_i(tx_flush),
    .pend_end_o(pend_end)
  );
  // request/strobe decode; a full burst yields before issuing one more strobe
  always_comb begin
    want_rd = !empty;
    want_wr = (tx_valid && !full) || pend_end;
    rd_cap = burst_q == MB && want_wr;
    wr_cap = burst_q == MB && want_rd;
    stall = rx_valid_q && !rx_ready;
    rd_go = state_q == RD && !empty && (!rx_valid_q || rx_ready) && !rd_cap;
    wr_go = state_q == WR && tx_valid && !full && !wr_cap;
    slrd = rd_go;
    slwr = wr_go;
    tx_ready = wr_go;
    pktend = state_q == PKTEND;
    fd_oe = state_q inside {ADR_IN, WR, PKTEND};
    fd_out = state_q == WR ? tx_data : 8'h00;
    fifoadr = adr_q;
    rx_data = rx_data_q;
    rx_valid = rx_valid_q;
    rx_data_d = rd_go ? fd_in : rx_data_q;
    rx_valid_d = rd_go || stall;
  end
  // next state; after an OUT burst yields, IDLE hands the bus to IN once so the directions alternate
  always_comb begin
    state_d = state_q;
    adr_d = adr_q;
    prefer_wr_d = prefer_wr_q;
    burst_d = (rd_go || wr_go) && burst_q != MB ? burst_q + 8'd1 : burst_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (want_rd && !(prefer_wr_q && want_wr)) begin
          state_d = ADR_OUT;
          adr_d = OUT_ADR;
          prefer_wr_d = 1'b0;
        end else if (want_wr) begin
          state_d = ADR_IN;
          adr_d = IN_ADR;
          prefer_wr_d = 1'b0;
        end
      end
      ADR_OUT: state_d = RD;
      RD: begin
        if (empty) state_d = IDLE;
        else if (rd_cap || (stall && want_wr)) begin
          state_d = IDLE;
          prefer_wr_d = 1'b1;
        end
      end
      ADR_IN: state_d = WR;
      WR: begin
        if (!tx_valid && pend_end) state_d = PKTEND;
        else if (full || !tx_valid || wr_cap) state_d = IDLE;
      end
      PKTEND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and rx holding registers
  always_ff @(posedge ifclk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      adr_q <= OUT_ADR;
      burst_q <= '0;
      prefer_wr_q <= 1'b0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q <= adr_d;
      burst_q <= burst_d;
      prefer_wr_q <= prefer_wr_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
`ifdef FX2_FIFO_MASTER_STATS_EN
  logic [31:0] rx_cnt_q, tx_cnt_q;
  logic [15:0] pk_cnt_q;
  // wrapping traffic statistics
  always_ff @(posedge ifclk or negedge reset_n)
    if (!reset_n) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
      pk_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_q + {31'd0, rd_go};
      tx_cnt_q <= tx_cnt_q + {31'd0, wr_go};
      pk_cnt_q <= pk_cnt_q + {15'd0, pktend};
    end
  assign rx_count = rx_cnt_q;
  assign tx_count = tx_cnt_q;
  assign pktend_count = pk_cnt_q;
`endif
endmodule
